if_id_stage: RTL

- IF/ID pipeline stage: accepts fetched instruction words plus their PC from fetch over a valid/ready handshake.
- Buffers them in a 2-entry skid buffer (main + skid register).
- Presents the head entry split into decoded fields (funct7, rs2, rs1, funct3, rd, opcode, PC) to the decode side, which feeds the ID_EX register.
- Supports back-pressure from downstream and a branch flush that injects a bubble.

---
 rtl/if_id_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// IF/ID stage: 2-entry skid buffer between fetch and decode.
// Optional IF_ID_IMM_GEN_EN adds an imm output decoded from the head entry.
module if_id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [6:0]      funct7,
  output logic [4:0]      rs2,
  output logic [4:0]      rs1,
  output logic [2:0]      funct3,
  output logic [4:0]      rd,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] PC_n
`ifdef IF_ID_IMM_GEN_EN
  ,
  output logic [XLEN-1:0] imm
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] main_i, main_i_n;
  logic [XLEN-1:0] main_pc, main_pc_n;
  logic [XLEN-1:0] skid_i, skid_i_n;
  logic [XLEN-1:0] skid_pc, skid_pc_n;
  logic            rdy_n;
  logic            accept;
  logic            pop;

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_n   = state;
    main_i_n  = main_i;
    main_pc_n = main_pc;
    skid_i_n  = skid_i;
    skid_pc_n = skid_pc;
    if (flush) begin
      state_n   = EMPTY;
      main_i_n  = '0;
      main_pc_n = '0;
      skid_i_n  = '0;
      skid_pc_n = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_i_n  = instr_in;
            main_pc_n = pc_in;
            state_n   = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept & pop: begin
              main_i_n  = instr_in;
              main_pc_n = pc_in;
            end
            accept & ~pop: begin
              skid_i_n  = instr_in;
              skid_pc_n = pc_in;
              state_n   = TWO;
            end
            ~accept & pop: begin
              main_i_n  = '0;
              main_pc_n = '0;
              state_n   = EMPTY;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            main_i_n  = skid_i;
            main_pc_n = skid_pc;
            state_n   = ONE;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
    rdy_n = (state_n != TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      main_i   <= '0;
      main_pc  <= '0;
      skid_i   <= '0;
      skid_pc  <= '0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_n;
      main_i   <= main_i_n;
      main_pc  <= main_pc_n;
      skid_i   <= skid_i_n;
      skid_pc  <= skid_pc_n;
      in_ready <= rdy_n;
    end
  end

  assign funct7 = main_i[31:25];
  assign rs2    = main_i[24:20];
  assign rs1    = main_i[19:15];
  assign funct3 = main_i[14:12];
  assign rd     = main_i[11:7];
  assign opcode = main_i[6:0];
  assign PC_n   = main_pc;

`ifdef IF_ID_IMM_GEN_EN
  always_comb begin
    imm = '0;
    case (main_i[6:0])
      7'b0000011,
      7'b0010011,
      7'b1100111:
        imm = {{(XLEN-12){main_i[31]}}, main_i[31:20]};
      7'b0100011:
        imm = {{(XLEN-12){main_i[31]}}, main_i[31:25], main_i[11:7]};
      7'b1100011:
        imm = {{(XLEN-13){main_i[31]}}, main_i[31], main_i[7],
               main_i[30:25], main_i[11:8], 1'b0};
      7'b0110111,
      7'b0010111:
        imm = {{(XLEN-32){main_i[31]}}, main_i[31:12], 12'b0};
      7'b1101111:
        imm = {{(XLEN-21){main_i[31]}}, main_i[31], main_i[19:12],
               main_i[20], main_i[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
`endif

endmodule
